phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/ubio_pkg.sv | 10 +
 rtl/phase_wait_cnt.sv | 22 ++
 rtl/phase_sequencer.sv | 95 +++++++++
 tb/tb_phase_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ubio_pkg.sv
// Shared phase codes for the sequencer, decoder and datapath.
package ubio_pkg;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH   = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXECUTE = 3'd3;
  localparam logic [STATE_W-1:0] ST_WBACK   = 3'd4;
endpackage

// File: rtl/phase_wait_cnt.sv
// EXECUTE wait-state counter: loads the extra-cycle count, counts down to zero.
module phase_wait_cnt #(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic [WAIT_W-1:0] count,
  output logic              zero
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   count <= '0;
    else if (clr)                count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - 1'b1;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: IDLE -> FETCH -> DECODE -> EXECUTE [-> WBACK] -> FETCH,
// with halt/stall control and a retired-instruction counter.
module phase_sequencer
  import ubio_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int WAIT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt,
  input  logic               stall,
  input  logic               mem_ready,
  input  logic [WAIT_W-1:0]  exec_wait,
  input  logic               wb_en,
  input  logic               cnt_clr,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               retire,
  output logic [CNT_W-1:0]   instr_cnt
);
  logic [STATE_W-1:0] state_nxt;
  logic               retire_nxt;
  logic               wait_load;
  logic               wait_dec;
  logic               wait_zero;
  logic [WAIT_W-1:0]  wait_count;

  phase_wait_cnt #(.WAIT_W(WAIT_W)) u_wait (
    .clk      (clk),
    .reset    (reset),
    .clr      (halt),
    .load     (wait_load),
    .dec      (wait_dec),
    .load_val (exec_wait),
    .count    (wait_count),
    .zero     (wait_zero)
  );

  // Halt beats everything; illegal codes recover to IDLE even while stalled.
  always_comb begin
    state_nxt  = state;
    retire_nxt = 1'b0;
    wait_load  = 1'b0;
    wait_dec   = 1'b0;
    if (halt) begin
      state_nxt = ST_IDLE;
    end else if (state > ST_WBACK) begin
      state_nxt = ST_IDLE;
    end else if (!stall) begin
      case (state)
        ST_IDLE:   if (start) state_nxt = ST_FETCH;
        ST_FETCH:  if (mem_ready) state_nxt = ST_DECODE;
        ST_DECODE: begin
          state_nxt = ST_EXECUTE;
          wait_load = 1'b1;
        end
        ST_EXECUTE: begin
          if (!wait_zero) begin
            wait_dec = 1'b1;
          end else if (wb_en) begin
            state_nxt = ST_WBACK;
          end else begin
            state_nxt  = ST_FETCH;
            retire_nxt = 1'b1;
          end
        end
        ST_WBACK: begin
          state_nxt  = ST_FETCH;
          retire_nxt = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      retire    <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state  <= state_nxt;
      retire <= retire_nxt;
      if (cnt_clr)         instr_cnt <= '0;
      else if (retire_nxt) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);

  logic unused_wait;
  assign unused_wait = ^wait_count;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: phase-level reference model plus literal checkpoints.
module tb_phase_sequencer;
  localparam int CNT_W  = 4;
  localparam int WAIT_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              halt = 1'b0;
  logic              stall = 1'b0;
  logic              mem_ready = 1'b0;
  logic [WAIT_W-1:0] exec_wait = '0;
  logic              wb_en = 1'b0;
  logic              cnt_clr = 1'b0;
  logic [2:0]        state;
  logic              busy;
  logic              retire;
  logic [CNT_W-1:0]  instr_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.CNT_W(CNT_W), .WAIT_W(WAIT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .halt      (halt),
    .stall     (stall),
    .mem_ready (mem_ready),
    .exec_wait (exec_wait),
    .wb_en     (wb_en),
    .cnt_clr   (cnt_clr),
    .state     (state),
    .busy      (busy),
    .retire    (retire),
    .instr_cnt (instr_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: phase plus "execute cycles still to run", counted from exec_wait+1.
  int m_state = 0, m_left = 0, m_cnt = 0;
  bit m_ret = 1'b0;
  int ns, nl;
  bit r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= 0; m_left <= 0; m_cnt <= 0; m_ret <= 1'b0;
    end else begin
      ns = m_state; nl = m_left; r = 1'b0;
      if (halt) begin
        ns = 0; nl = 0;
      end else if (!stall) begin
        case (m_state)
          0: if (start) ns = 1;
          1: if (mem_ready) ns = 2;
          2: begin ns = 3; nl = int'(exec_wait) + 1; end
          3: if (m_left > 1) nl = m_left - 1;
             else if (wb_en) ns = 4;
             else begin ns = 1; r = 1'b1; end
          4: begin ns = 1; r = 1'b1; end
          default: ns = 0;
        endcase
      end
      m_state <= ns;
      m_left  <= nl;
      m_ret   <= r;
      if (cnt_clr) m_cnt <= 0;
      else if (r)  m_cnt <= (m_cnt + 1) % (1 << CNT_W);
    end
  end

  always @(negedge clk) begin
    chk("state", 32'(state), 32'(m_state));
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("retire", 32'(retire), 32'(m_ret));
    chk("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
  end

  int exp_a [12] = '{2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4, 1};
  int exp_b [12] = '{2, 3, 3, 3, 3, 1, 2, 3, 3, 3, 3, 1};

  initial begin
    logic [CNT_W-1:0] held;
    int k;
    #1 reset = 1'b1;
    #11;
    chk("rst_state", 32'(state), 0);
    chk("rst_cnt", 32'(instr_cnt), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_busy", 32'(busy), 0);
    tick();
    reset = 1'b0;
    tick(); chk("idle_hold", 32'(state), 0);
    tick(); chk("idle_hold", 32'(state), 0);

    // Back-to-back single-cycle execute with writeback: period 4
    mem_ready = 1'b1; wb_en = 1'b1; exec_wait = 0; start = 1'b1;
    tick(); chk("a_fetch", 32'(state), 1);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("a_state", 32'(state), 32'(exp_a[i]));
      chk("a_retire", 32'(retire), 32'(i % 4 == 3));
    end
    chk("a_cnt", 32'(instr_cnt), 3);
    halt = 1'b1;
    tick(); chk("a_halt", 32'(state), 0);
    halt = 1'b0; cnt_clr = 1'b1;
    tick(); chk("a_clr", 32'(instr_cnt), 0);
    cnt_clr = 1'b0;

    // start with halt in IDLE stays IDLE
    start = 1'b1; halt = 1'b1;
    tick(); chk("start_halt", 32'(state), 0);
    halt = 1'b0;

    // Long execute, no writeback: period 6; clear wins on the second retire
    exec_wait = 3; wb_en = 1'b0;
    tick(); chk("b_fetch", 32'(state), 1);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 11) cnt_clr = 1'b1;
      tick();
      chk("b_state", 32'(state), 32'(exp_b[i]));
      if (i == 5) begin
        chk("b_retire1", 32'(retire), 1);
        chk("b_cnt1", 32'(instr_cnt), 1);
      end
    end
    chk("b_clr_retire", 32'(retire), 1);
    chk("b_clr_cnt", 32'(instr_cnt), 0);
    cnt_clr = 1'b0;

    // FETCH held by memory for 5 cycles
    mem_ready = 1'b0; exec_wait = 2;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("c_fetch_hold", 32'(state), 1);
    end
    mem_ready = 1'b1;
    tick(); chk("c_decode", 32'(state), 2);

    // Stall in EXECUTE with two wait cycles pending
    tick(); chk("d_exec", 32'(state), 3);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("d_stall", 32'(state), 3);
    end
    stall = 1'b0;
    tick(); chk("d_exec1", 32'(state), 3);
    tick(); chk("d_exec0", 32'(state), 3);
    tick(); chk("d_done", 32'(state), 1);
    chk("d_retire", 32'(retire), 1);

    // Halt on the WBACK->FETCH edge suppresses the retire
    wb_en = 1'b1; exec_wait = 0;
    k = 0;
    while (state != 3'd4 && k < 10) begin tick(); k++; end
    chk("e_reach_wback", 32'(state), 4);
    held = instr_cnt;
    halt = 1'b1;
    tick();
    chk("e_halt_state", 32'(state), 0);
    chk("e_halt_retire", 32'(retire), 0);
    chk("e_halt_cnt", 32'(instr_cnt), 32'(held));
    halt = 1'b0;

    // Counter wrap 15 -> 0
    wb_en = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    k = 0;
    while (instr_cnt != 4'd15 && k < 200) begin tick(); k++; end
    chk("w_reach15", 32'(instr_cnt), 15);
    k = 0;
    do begin tick(); k++; end while (retire != 1'b1 && k < 10);
    chk("w_retire", 32'(retire), 1);
    chk("w_wrap", 32'(instr_cnt), 0);

    // Async reset in the middle of EXECUTE
    exec_wait = 5; wb_en = 1'b1;
    k = 0;
    do begin tick(); k++; end while (retire != 1'b1 && k < 30);
    chk("f_retire", 32'(retire), 1);
    k = 0;
    while (state != 3'd3 && k < 10) begin tick(); k++; end
    chk("f_reach_exec", 32'(state), 3);
    chk("f_cnt_pre", 32'(instr_cnt), 1);
    #2 reset = 1'b1;
    #1;
    chk("f_rst_state", 32'(state), 0);
    chk("f_rst_cnt", 32'(instr_cnt), 0);
    chk("f_rst_retire", 32'(retire), 0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("f_idle", 32'(state), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "timeout");
  end
endmodule
